// File: rtl/genius_pkg.sv
// Shared definitions for the Genius memory game: state encoding, colour codes
// and the fixed 16-step colour sequence.
package genius_pkg;

    localparam int SEQ_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW_ON  = 3'd1,
        ST_SHOW_GAP = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_ECHO     = 3'd4,
        ST_LEVEL_UP = 3'd5,
        ST_LOSE     = 3'd6,
        ST_WIN      = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        COL_0    = 2'd0,
        COL_1    = 2'd1,
        COL_2    = 2'd2,
        COL_NONE = 2'd3
    } color_e;

    // Entry 0 sits in the least significant slot.
    localparam logic [SEQ_LEN-1:0][1:0] SEQ_ROM = {
        2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0
    };

    localparam logic [2:0] LAMP_LOSE = 3'b111;
    localparam logic [2:0] LAMP_WIN  = 3'b010;

    function automatic color_e rom_color(input logic [3:0] idx);
        return color_e'(SEQ_ROM[idx]);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/genius_game_ctrl_if.sv
// Player-facing signals of the game controller: start/buttons in, lamps and
// status out.
interface genius_game_ctrl_if;
    logic       start;
    logic [2:0] bt;
    logic [2:0] color;
    logic [4:0] level;
    logic       busy;
    logic       lose;
    logic       win;
    logic [2:0] state_dbg;

    modport master (
        output start, bt,
        input  color, level, busy, lose, win, state_dbg
    );

    modport slave (
        input  start, bt,
        output color, level, busy, lose, win, state_dbg
    );
endinterface

// File: rtl/genius_color_onehot.sv
// 2-bit colour code to one-hot lamp drive; the unused code lights nothing.
module genius_color_onehot
    import genius_pkg::*;
(
    input  color_e     code,
    output logic [2:0] onehot
);
    always_comb begin
        onehot = 3'b000;
        case (code)
            COL_0:   onehot = 3'b001;
            COL_1:   onehot = 3'b010;
            COL_2:   onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    end
endmodule

// File: rtl/genius_game_ctrl.sv
// Genius (Simon) game controller: plays back a growing prefix of the ROM
// sequence, then checks the player's button echo against it.
module genius_game_ctrl
    import genius_pkg::*;
#(
    parameter int SHOW_ON  = 4,
    parameter int SHOW_GAP = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic              clock,
    input  logic              reset,
    genius_game_ctrl_if.slave io
);
    localparam int TMAX = max3(SHOW_ON, SHOW_GAP, TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_ON   = TW'(SHOW_ON - 1);
    localparam logic [TW-1:0] T_GAP  = TW'(SHOW_GAP - 1);
    localparam logic [TW-1:0] T_IDLE = TW'(TIMEOUT - 1);

    state_e        state_q, state_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [4:0]    idx_q, idx_n;
    logic [4:0]    level_q, level_n;
    logic          lose_q, lose_n;
    logic          win_q, win_n;
    logic [2:0]    color_q, color_n;
    logic          busy_q, busy_n;

    logic [2:0]    exp_bt;
    logic [2:0]    lamp_seq;
    logic          more;

    genius_color_onehot u_exp (
        .code   (rom_color(idx_q[3:0])),
        .onehot (exp_bt)
    );

    // Lamp follows the next index so it switches together with the state.
    genius_color_onehot u_lamp (
        .code   (rom_color(idx_n[3:0])),
        .onehot (lamp_seq)
    );

    assign more = (idx_q + 5'd1) < level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            level_q <= '0;
            lose_q  <= 1'b0;
            win_q   <= 1'b0;
            color_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            idx_q   <= idx_n;
            level_q <= level_n;
            lose_q  <= lose_n;
            win_q   <= win_n;
            color_q <= color_n;
            busy_q  <= busy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        idx_n   = idx_q;
        level_n = level_q;
        lose_n  = lose_q;
        win_n   = win_q;

        case (state_q)
            ST_IDLE, ST_LOSE, ST_WIN: begin
                if (io.start) begin
                    state_n = ST_SHOW_ON;
                    level_n = 5'd1;
                    idx_n   = '0;
                    timer_n = '0;
                    lose_n  = 1'b0;
                    win_n   = 1'b0;
                end
            end
            ST_SHOW_ON: begin
                if (timer_q == T_ON) begin
                    state_n = ST_SHOW_GAP;
                    timer_n = '0;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (timer_q == T_GAP) begin
                    timer_n = '0;
                    if (more) begin
                        idx_n   = idx_q + 5'd1;
                        state_n = ST_SHOW_ON;
                    end else begin
                        idx_n   = '0;
                        state_n = ST_WAIT_IN;
                    end
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            ST_WAIT_IN: begin
                if (io.bt == 3'b000) begin
                    if (timer_q == T_IDLE) begin
                        state_n = ST_LOSE;
                        lose_n  = 1'b1;
                    end else begin
                        timer_n = timer_q + TW'(1);
                    end
                end else if (io.bt == exp_bt) begin
                    state_n = ST_ECHO;
                    timer_n = '0;
                end else begin
                    // Wrong colour or a chord of several buttons.
                    state_n = ST_LOSE;
                    lose_n  = 1'b1;
                end
            end
            ST_ECHO: begin
                if (timer_q == T_ON) begin
                    timer_n = '0;
                    if (more) begin
                        idx_n   = idx_q + 5'd1;
                        state_n = ST_WAIT_IN;
                    end else begin
                        state_n = ST_LEVEL_UP;
                    end
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            ST_LEVEL_UP: begin
                if (level_q == 5'(SEQ_LEN)) begin
                    state_n = ST_WIN;
                    win_n   = 1'b1;
                end else begin
                    level_n = level_q + 5'd1;
                    idx_n   = '0;
                    timer_n = '0;
                    state_n = ST_SHOW_ON;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        color_n = 3'b000;
        case (state_n)
            ST_SHOW_ON, ST_ECHO: color_n = lamp_seq;
            ST_LOSE:             color_n = LAMP_LOSE;
            ST_WIN:              color_n = LAMP_WIN;
            default:             color_n = 3'b000;
        endcase
        busy_n = (state_n == ST_SHOW_ON) || (state_n == ST_SHOW_GAP);
    end

    assign io.color     = color_q;
    assign io.level     = level_q;
    assign io.busy      = busy_q;
    assign io.lose      = lose_q;
    assign io.win       = win_q;
    assign io.state_dbg = state_q;

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Directed bench for genius_game_ctrl: cycle table for the first levels plus
// hand sequences for timeout, full win and reset/chord corner cases.
module tb_genius_game_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int seq [16] = '{0, 1, 0, 1, 0, 2, 0, 2, 0, 1, 0, 2, 0, 1, 0, 1};

    genius_game_ctrl_if io ();

    genius_game_ctrl #(.SHOW_ON(4), .SHOW_GAP(2), .TIMEOUT(64)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       st;
        logic [2:0] bt;
        int         n;
        logic [2:0] col;
        logic [4:0] lvl;
        logic       busy;
        logic       lose;
        logic       win;
        logic [2:0] state;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic s, input logic [2:0] b,
                                input int n, input logic [2:0] c, input logic [4:0] l,
                                input logic bz, input logic ls, input logic w,
                                input logic [2:0] st);
        vec_t v;
        v.rst = r; v.st = s; v.bt = b; v.n = n; v.col = c; v.lvl = l;
        v.busy = bz; v.lose = ls; v.win = w; v.state = st;
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {io.color, io.level, io.busy, io.lose, io.win, io.state_dbg};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input bit noisy);
        int k = 0;
        while (io.state_dbg !== tgt && k < budget) begin
            if (noisy && io.busy === 1'b1 && $urandom_range(0, 2) == 0)
                io.bt = 3'($urandom_range(1, 7));
            tick();
            io.bt = 3'b000;
            k++;
        end
        chk($sformatf("wait_state_%0d", tgt), {29'd0, io.state_dbg}, {29'd0, tgt});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io.start = 1'b0;
        io.bt = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
    endtask

    task automatic play_level(input int lv, input bit noisy);
        wait_state(3'd3, 500, noisy);
        chk($sformatf("level_%0d", lv), {27'd0, io.level}, 32'(lv));
        for (int i = 0; i < lv; i++) begin
            io.bt = 3'(1 << seq[i]);
            tick();
            io.bt = 3'b000;
            chk($sformatf("echo_l%0d_i%0d", lv, i), {26'd0, io.color, io.state_dbg},
                {26'd0, 3'(1 << seq[i]), 3'd4});
            wait_state((i < lv - 1) ? 3'd3 : 3'd5, 20, 1'b0);
        end
    endtask

    initial begin
        io.start = 1'b0;
        io.bt    = 3'b000;

        //             rst  st   bt      n  col     lvl  bz  ls  w  state
        tbl.push_back(mk(1, 0, 3'b000, 2, 3'b000, 0, 0, 0, 0, 3'd0));
        tbl.push_back(mk(0, 0, 3'b000, 2, 3'b000, 0, 0, 0, 0, 3'd0));
        tbl.push_back(mk(0, 1, 3'b000, 1, 3'b001, 1, 1, 0, 0, 3'd1));
        tbl.push_back(mk(0, 0, 3'b000, 3, 3'b001, 1, 1, 0, 0, 3'd1));
        tbl.push_back(mk(0, 0, 3'b000, 2, 3'b000, 1, 1, 0, 0, 3'd2));
        tbl.push_back(mk(0, 0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 3'd3));
        tbl.push_back(mk(0, 0, 3'b001, 1, 3'b001, 1, 0, 0, 0, 3'd4));
        tbl.push_back(mk(0, 0, 3'b100, 3, 3'b001, 1, 0, 0, 0, 3'd4));
        tbl.push_back(mk(0, 0, 3'b000, 1, 3'b000, 1, 0, 0, 0, 3'd5));
        tbl.push_back(mk(0, 0, 3'b000, 1, 3'b001, 2, 1, 0, 0, 3'd1));
        tbl.push_back(mk(0, 0, 3'b100, 3, 3'b001, 2, 1, 0, 0, 3'd1));
        tbl.push_back(mk(0, 0, 3'b000, 2, 3'b000, 2, 1, 0, 0, 3'd2));
        tbl.push_back(mk(0, 0, 3'b000, 4, 3'b010, 2, 1, 0, 0, 3'd1));
        tbl.push_back(mk(0, 0, 3'b000, 2, 3'b000, 2, 1, 0, 0, 3'd2));
        tbl.push_back(mk(0, 0, 3'b000, 1, 3'b000, 2, 0, 0, 0, 3'd3));
        tbl.push_back(mk(0, 0, 3'b001, 1, 3'b001, 2, 0, 0, 0, 3'd4));
        tbl.push_back(mk(0, 0, 3'b000, 3, 3'b001, 2, 0, 0, 0, 3'd4));
        tbl.push_back(mk(0, 0, 3'b000, 1, 3'b000, 2, 0, 0, 0, 3'd3));
        tbl.push_back(mk(0, 0, 3'b100, 1, 3'b111, 2, 0, 1, 0, 3'd6));
        tbl.push_back(mk(0, 0, 3'b000, 2, 3'b111, 2, 0, 1, 0, 3'd6));
        tbl.push_back(mk(0, 1, 3'b000, 1, 3'b001, 1, 1, 0, 0, 3'd1));
        tbl.push_back(mk(1, 0, 3'b000, 1, 3'b000, 0, 0, 0, 0, 3'd0));

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                reset    = tbl[i].rst;
                io.start = (k == 0) ? tbl[i].st : 1'b0;
                io.bt    = (k == 0) ? tbl[i].bt : 3'b000;
                tick();
                chk($sformatf("vec%0d_c%0d", i, k), {18'd0, outs()},
                    {18'd0, tbl[i].col, tbl[i].lvl, tbl[i].busy, tbl[i].lose,
                     tbl[i].win, tbl[i].state});
            end
        end
        io.start = 1'b0;
        io.bt    = 3'b000;

        // Timeout: 63 idle cycles still waiting, the 64th loses.
        do_reset();
        do_start();
        wait_state(3'd3, 50, 1'b0);
        repeat (63) tick();
        chk("timeout_63_wait", {29'd0, io.state_dbg}, 32'd3);
        chk("timeout_63_lose", {31'd0, io.lose}, 32'd0);
        tick();
        chk("timeout_64", {28'd0, io.lose, io.color}, {28'd0, 1'b1, 3'b111});

        // Press on the last allowed idle cycle is accepted.
        do_start();
        chk("restart_clear", {27'd0, io.lose, io.level}, {27'd0, 1'b0, 5'd1});
        wait_state(3'd3, 50, 1'b0);
        repeat (63) tick();
        io.bt = 3'b001;
        tick();
        io.bt = 3'b000;
        chk("press_at_63", {28'd0, io.lose, io.state_dbg}, {28'd0, 1'b0, 3'd4});

        // Full game with stray presses during playback.
        do_reset();
        do_start();
        for (int lv = 1; lv <= 16; lv++) play_level(lv, 1'b1);
        tick();
        chk("win", {18'd0, outs()}, {18'd0, 3'b010, 5'd16, 1'b0, 1'b0, 1'b1, 3'd7});
        repeat (3) tick();
        chk("win_sticky", {28'd0, io.win, io.state_dbg}, {28'd0, 1'b1, 3'd7});

        // Reset mid-playback at level 3, then a two-button chord.
        do_reset();
        do_start();
        play_level(1, 1'b0);
        play_level(2, 1'b0);
        wait_state(3'd1, 5, 1'b0);
        chk("level3_show", {26'd0, io.level, io.busy}, {26'd0, 5'd3, 1'b1});
        reset = 1'b1;
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        chk("reset_mid_show", {18'd0, outs()}, 32'd0);
        reset = 1'b0;
        do_start();
        wait_state(3'd3, 50, 1'b0);
        io.bt = 3'b011;
        tick();
        io.bt = 3'b000;
        chk("chord_lose", {25'd0, io.lose, io.color, io.state_dbg},
            {25'd0, 1'b1, 3'b111, 3'd6});

        // Start is ignored while a game is running.
        do_start();
        wait_state(3'd3, 50, 1'b0);
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        chk("start_ignored", {27'd0, io.state_dbg, io.busy, io.lose},
            {27'd0, 3'd3, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/genius_game_ctrl.md
GENIUS_GAME_CTRL -- requirements
Module: genius_game_ctrl

Interface
REQ-001 Parameter SHOW_ON, default 4: cycles a colour is lit during playback.
REQ-002 Parameter SHOW_GAP, default 2: dark cycles between playback colours.
REQ-003 Parameter TIMEOUT, default 64: idle cycles allowed per player input before loss.
REQ-004 Port clock  in  1: single clock; all logic is on its rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port start  in  1: single-cycle pulse that begins a game.
REQ-007 Port bt  in  3: one-hot, debounced, single-cycle button pulses for colours 0/1/2.
REQ-008 Port color  out  3: one-hot colour lamp.
REQ-009 Port level  out  5: current sequence length, 0 when idle, 1..16 in play.
REQ-010 Port busy  out  1: high during playback, which means buttons are ignored.
REQ-011 Port lose  out  1: sticky loss flag.
REQ-012 Port win  out  1: sticky win flag.
REQ-013 Port state_dbg  out  3: state encoding.

Function
REQ-014 Sequence is a fixed 16-entry ROM of 2-bit colours: 0,1,0,1,0,2,0,2,0,1,0,2,0,1,0,1.
REQ-015 FSM states: IDLE, SHOW_ON, SHOW_GAP, WAIT_IN, ECHO, LEVEL_UP, LOSE, WIN.
REQ-016 IDLE: start -> level=1, idx=0, clear lose/win, go to SHOW_ON.
REQ-017 SHOW_ON: color=onehot(rom[idx]) for exactly SHOW_ON cycles, then go to SHOW_GAP.
REQ-018 SHOW_GAP: color=0 for SHOW_GAP cycles; then if idx+1<level, increment idx and go to SHOW_ON; else set idx=0, clear the timer and go to WAIT_IN.
REQ-019 busy=1 in SHOW_ON/SHOW_GAP only.
REQ-020 WAIT_IN with bt==0: timer increments; when timer reaches TIMEOUT -> LOSE.
REQ-021 WAIT_IN with bt==onehot(rom[idx]): go to ECHO and light that colour for SHOW_ON cycles.
REQ-022 WAIT_IN with wrong bt, or more than one bt bit set: go to LOSE on the next cycle.
REQ-023 ECHO end: if idx+1<level, increment idx, clear the timer, go to WAIT_IN; else go to LEVEL_UP.
REQ-024 Buttons are ignored in ECHO.
REQ-025 LEVEL_UP, one cycle: if level==16 -> WIN; else increment level, set idx=0, go to SHOW_ON.
REQ-026 LOSE/WIN: set the flag, color=3'b111 (LOSE) or color=3'b010 (WIN); remain until start.
REQ-027 start from LOSE/WIN behaves as in IDLE (REQ-016).
REQ-028 start in any other state is ignored.
REQ-029 Counters saturate-free: the timer is wide enough for max(SHOW_ON,SHOW_GAP,TIMEOUT); idx and level are 5 bits.
REQ-030 Outputs are registered: a state change shows on color one cycle after the deciding edge.

Reset
REQ-031 reset has priority over all inputs, including start.
REQ-032 On reset: state=IDLE, color=0, level=0, busy=0, lose=0, win=0, idx=0, timer=0.
REQ-033 reset asserted mid-playback or mid-input returns to IDLE on the next edge with no lamp glitch.

Structure
REQ-034 Shared package genius_pkg holds the state encoding, colour enum (2-bit), SEQ_LEN=16 and the ROM contents.
REQ-035 One sub-module, genius_color_onehot, converts a 2-bit colour to 3-bit one-hot, with code 3 mapping to 0.

Verification
REQ-036 reset, start -> SHOW_ON; color=001 for 4 cycles, then 000 for 2, then WAIT_IN with level=1.
REQ-037 level 1, bt=001 -> ECHO 4 cycles; LEVEL_UP; level=2; playback shows 001 then 010.
REQ-038 At level 2, bt=001 then bt=100 -> lose=1, color=111; a later start clears lose and sets level=1.
REQ-039 WAIT_IN with no press for 64 cycles -> lose=1 at cycle 64; a press at cycle 63 is accepted.
REQ-040 Full correct play of 16 levels -> win=1, color=010, level=16; bt pulses during busy have no effect.
REQ-041 reset during SHOW_ON at level 3 -> next cycle all outputs at reset values; bt=011 in WAIT_IN -> LOSE.
